// File: rtl/alu.sv
// 32-bit ALU with a single registered result stage.
// Inputs sampled on the rising edge of clk; output1/cout hold the result until the next edge.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    input  logic [2:0]  opsel,
    input  logic        mode,
    output logic [31:0] output1,
    output logic        cout
);

    // Operation codes, shared by the two groups and told apart by mode.
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SBB    = 3'b001;
    localparam logic [2:0] OP_MOV    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_INC    = 3'b100;
    localparam logic [2:0] OP_DEC    = 3'b101;
    localparam logic [2:0] OP_ADDINC = 3'b110;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_NOT    = 3'b011;
    localparam logic [2:0] OP_SHL    = 3'b101;

    typedef struct packed {
        logic        c;
        logic [31:0] r;
    } res_t;

    logic [32:0] a33, b33, ci33;
    res_t        nxt;

    assign a33  = {1'b0, A};
    assign b33  = {1'b0, B};
    assign ci33 = {32'd0, cin};

    // Next result: 33-bit unsigned arithmetic so bit 32 is carry (add) or borrow (subtract).
    always_comb begin
        nxt = '0;
        if (!mode) begin
            unique case (opsel)
                OP_ADD:    nxt = a33 + b33 + ci33;
                OP_SBB:    nxt = a33 - b33 - ci33;
                OP_MOV:    nxt = {1'b0, A};
                OP_SUB:    nxt = a33 - b33;
                OP_INC:    nxt = a33 + 33'd1;
                OP_DEC:    nxt = a33 - 33'd1;
                OP_ADDINC: nxt = a33 + b33 + 33'd1;
                default:   nxt = '0;
            endcase
        end else begin
            unique case (opsel)
                OP_AND:  nxt = {1'b0, A & B};
                OP_OR:   nxt = {1'b0, A | B};
                OP_XOR:  nxt = {1'b0, A ^ B};
                OP_NOT:  nxt = {1'b0, ~A};
                OP_SHL:  nxt = {A, 1'b0};      // A[31] lands in the flag bit
                default: nxt = '0;
            endcase
        end
    end

    // Output register; async reset clears any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output1 <= '0;
            cout    <= 1'b0;
        end else begin
            output1 <= nxt.r;
            cout    <= nxt.c;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: expected results queued at drive time, popped and checked after the edge.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cin = 1'b0;
    logic [2:0]  opsel = '0;
    logic        mode = 1'b0;
    logic [31:0] output1;
    logic        cout;

    int n_eval = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic        c;
    } exp_t;

    exp_t sb[$];

    alu dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .cin(cin),
        .opsel(opsel), .mode(mode), .output1(output1), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk_r(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s output1 got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic obs, input logic exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cout got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one op between edges, queue its expectation, then check after the capture edge.
    task automatic step(input string tag, input logic m, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic [31:0] er, input logic ec);
        exp_t e;
        @(negedge clk);
        mode = m; opsel = op; A = a; B = b; cin = ci;
        e.tag = tag; e.r = er; e.c = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_eval++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard empty got 0 entries expected 1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk_r(e.tag, output1, e.r);
            chk_c(e.tag, cout, e.c);
        end
    endtask

    initial begin
        // Reset held from time 0: outputs must already be zero.
        #1;
        chk_r("reset_init", output1, 32'h0);
        chk_c("reset_init", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_add", 0, 3'b000, 32'd1, 32'd2, 0, 32'h00000003, 0);

        // Mid-operation reset: asserted between edges, takes effect immediately.
        step("pre_rst", 0, 3'b010, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_r("async_rst", output1, 32'h0);
        chk_c("async_rst", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_r("post_release", output1, 32'h0);

        // Arithmetic sweep
        step("add",    0, 3'b000, 32'h55555555, 32'hAAAAAAAA, 0, 32'hFFFFFFFF, 0);
        step("sbb",    0, 3'b001, 32'h55555555, 32'hAAAAAAAA, 0, 32'hAAAAAAAB, 1);
        step("mov",    0, 3'b010, 32'h55555555, 32'hAAAAAAAA, 0, 32'h55555555, 0);
        step("sub",    0, 3'b011, 32'h55555555, 32'hAAAAAAAA, 0, 32'hAAAAAAAB, 1);
        step("inc",    0, 3'b100, 32'h55555555, 32'hAAAAAAAA, 0, 32'h55555556, 0);
        step("dec",    0, 3'b101, 32'h55555555, 32'hAAAAAAAA, 0, 32'h55555554, 0);
        step("addinc", 0, 3'b110, 32'h55555555, 32'hAAAAAAAA, 0, 32'h00000000, 1);
        step("a_rsv",  0, 3'b111, 32'h55555555, 32'hAAAAAAAA, 1, 32'h00000000, 0);

        // Logic sweep
        step("and", 1, 3'b000, 32'h55555555, 32'hAAAAAAAA, 0, 32'h00000000, 0);
        step("or",  1, 3'b001, 32'h55555555, 32'hAAAAAAAA, 0, 32'hFFFFFFFF, 0);
        step("xor", 1, 3'b010, 32'h55555555, 32'hAAAAAAAA, 0, 32'hFFFFFFFF, 0);
        step("not", 1, 3'b011, 32'h55555555, 32'hAAAAAAAA, 0, 32'hAAAAAAAA, 0);
        step("shl", 1, 3'b101, 32'h55555555, 32'hAAAAAAAA, 0, 32'hAAAAAAAA, 0);

        // Wrap / carry
        step("add_wrap", 0, 3'b000, 32'hFFFFFFFF, 32'h55555555, 0, 32'h55555554, 1);
        step("inc_wrap", 0, 3'b100, 32'hFFFFFFFF, 32'h55555555, 0, 32'h00000000, 1);
        step("shl_msb",  1, 3'b101, 32'hFFFFFFFF, 32'h55555555, 0, 32'hFFFFFFFE, 1);
        step("sub_nb",   0, 3'b011, 32'hFFFFFFFF, 32'h55555555, 0, 32'hAAAAAAAA, 0);

        // Zero operand
        step("dec_zero", 0, 3'b101, 32'h0, 32'hAAAAAAAA, 0, 32'hFFFFFFFF, 1);
        step("sub_zero", 0, 3'b011, 32'h0, 32'hAAAAAAAA, 0, 32'h55555556, 1);
        step("not_zero", 1, 3'b011, 32'h0, 32'hAAAAAAAA, 0, 32'hFFFFFFFF, 0);
        step("and_zero", 1, 3'b000, 32'h0, 32'hAAAAAAAA, 0, 32'h00000000, 0);

        // cin handling and reserved codes
        step("add_cin",  0, 3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 32'hFFFFFFFF, 0);
        step("sbb_cin",  0, 3'b001, 32'd5, 32'd5, 1, 32'hFFFFFFFF, 1);
        step("mov_cin",  0, 3'b010, 32'h12345678, 32'h0, 1, 32'h12345678, 0);
        step("l_rsv100", 1, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 0);
        step("l_rsv110", 1, 3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 0);
        step("l_rsv111", 1, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 0);

        n_eval++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain leftover got %0d expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

32-bit arithmetic/logic unit with registered outputs. It takes two 32-bit operands, a carry/borrow input, a 3-bit operation select and a mode bit. Each rising clock edge it registers one result word and one carry/borrow flag. It is the datapath execution block, fed directly by operand and decode logic, with one cycle of latency.

## Interface
- No parameters; data width is fixed at 32.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  32  operand A (unsigned).
- B  input  32  operand B (unsigned).
- cin  input  1  carry-in for ADD, borrow-in for SBB; ignored by all other operations.
- opsel  input  3  operation select (meaning depends on mode).
- mode  input  1  0 = arithmetic group, 1 = logic group.
- output1  output  32  registered result.
- cout  output  1  registered carry/borrow flag.

## Operation
- All arithmetic is computed 33 bits wide and unsigned.
  - output1 takes bits [31:0]; cout takes bit 32 where stated.
  - Results wrap modulo 2^32.
- Arithmetic group (mode=0):
  - 000 ADD: A + B + cin; cout = carry out.
  - 001 SBB: A - B - cin; cout = borrow (1 when A < B + cin).
  - 010 MOV: A; cout = 0.
  - 011 SUB: A - B; cout = borrow (1 when A < B).
  - 100 INC: A + 1; cout = 1 only when A = 0xFFFFFFFF.
  - 101 DEC: A - 1; cout = 1 (borrow) only when A = 0x00000000.
  - 110 ADDINC: A + B + 1; cout = carry out.
  - 111 reserved: output1 = 0, cout = 0.
- Logic group (mode=1); cout = 0 unless stated:
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 XOR: A ^ B.
  - 011 NOT: ~A (B ignored).
  - 101 SHL: A << 1 with bit 0 filled with 0; cout = A[31].
  - 100, 110, 111 reserved: output1 = 0, cout = 0.
- Any input value containing X/Z has no defined result.
- Legal-code results must be deterministic for all 2^32 × 2^32 operand pairs.

## Timing
- Reset: while rst_n = 0, output1 = 0x00000000 and cout = 0, applied immediately without waiting for clk.
- Reset release: the first capture happens on the first rising clk edge after rst_n rises.
- Latency: the result for inputs present at rising edge N appears on output1/cout just after edge N and holds until edge N+1.
- Throughput: one operation per cycle; no handshake and no stall.
- Inputs may change freely between edges; only values at the sampling edge matter.
- Reset asserted mid-operation discards the in-flight result; outputs are 0 until the first edge after release.
- Back-to-back changes to mode or opsel take effect on the very next edge; there is no state carried between operations.

## Test plan
- Reset: drive rst_n=0 asynchronously between edges -> output1=0x00000000 and cout=0 immediately; release, then ADD with A=1, B=2 -> 0x00000003 after the next edge.
- Arithmetic sweep, A=0x55555555, B=0xAAAAAAAA, cin=0, mode=0, one edge per op:
  - ADD -> 0xFFFFFFFF, cout=0.
  - SBB -> 0xAAAAAAAB, cout=1.
  - MOV -> 0x55555555, cout=0.
  - SUB -> 0xAAAAAAAB, cout=1.
  - INC -> 0x55555556, cout=0.
  - DEC -> 0x55555554, cout=0.
  - ADDINC -> 0x00000000, cout=1.
- Logic sweep, same operands, mode=1:
  - AND -> 0x00000000.
  - OR -> 0xFFFFFFFF.
  - XOR -> 0xFFFFFFFF.
  - NOT -> 0xAAAAAAAA.
  - SHL -> 0xAAAAAAAA, cout=0.
- Wrap/carry, A=0xFFFFFFFF, B=0x55555555:
  - ADD -> 0x55555554, cout=1.
  - INC -> 0x00000000, cout=1.
  - SHL -> 0xFFFFFFFE, cout=1.
  - SUB -> 0xAAAAAAAA, cout=0.
- Zero operand, A=0, B=0xAAAAAAAA:
  - DEC -> 0xFFFFFFFF, cout=1.
  - SUB -> 0x55555556, cout=1.
  - NOT -> 0xFFFFFFFF.
  - AND -> 0.
- cin and reserved codes:
  - ADD with A=B=0x7FFFFFFF, cin=1 -> 0xFFFFFFFF, cout=0.
  - SBB with A=5, B=5, cin=1 -> 0xFFFFFFFF, cout=1.
  - mode=1, opsel=100 -> 0x00000000, cout=0.
